control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit for the datapath. Drives the register, PC, IR, MAR, MDR, Y, Z, HI and LO in/out strobes and ALUselect.
//  Runs fetch/execute one micro-step (T-state) per clock, and stalls on a memory ready handshake.
//  Decodes IR fields ra/rb/rc into one-hot R_in/R_out vectors for the 16 GPRs.
// PARAMETERS
//  NREGS      16  number of GPRs (R_in/R_out width)
//  OPW        5   opcode width, IR[31:27]
// PORTS
//  clock      in   1   single system clock, rising edge
//  clear      in   1   synchronous, active-high reset
//  ir         in   32  IR contents: op=[31:27] ra=[26:23] rb=[22:19] rc=[18:15] C=[18:0]
//  con_ff     in   1   branch condition result (external CON FF)
//  mem_ready  in   1   memory has completed the current read or write
//  stop       in   1   halt at the next instruction boundary
//  R_in/R_out out  16  one-hot GPR load/drive strobes
//  PCin PCout IRin Yin Zin MARin MDRin MDRout MDRread HIin HIout LOin LOout IncPC Zhighout Zlowout Cout  out 1 each
//  ALUselect  out  4   ALU operation code
//  mem_read   out  1   memory read request
//  mem_write  out  1   memory write request
//  run        out  1   high while sequencing instructions
//  illegal    out  1   sticky illegal-opcode flag (0 if CTRL_ILLEGAL_TRAP_EN undefined)
// BEHAVIOUR
//  - Outputs are decoded combinationally from the registered state and ir. At most one bus driver is active per cycle.
//  - clear: next state = RST. In RST all strobes, mem_read, mem_write, run and illegal are 0. RST -> T0 on the first cycle with clear low.
//  - A clear mid-instruction aborts it. No partial register write occurs after that edge.
//  - Fetch:
//     T0: PCout MARin IncPC.
//     T1: MDRread MDRin mem_read. Hold T1 until mem_ready=1.
//     T2: MDRout IRin.
//  - ALU R-type (add sub and or shr shl ror rol):
//     T3: Grb->R_out, Yin.
//     T4: Grc->R_out, ALUselect=op, Zin.
//     T5: Zlowout, Gra->R_in.
//  - Immediate (addi andi ori): T3 as R-type; T4: Cout, ALUselect, Zin; T5 as R-type.
//  - neg/not: T3: Grb out, ALUselect, Zin. T4: Zlowout, Gra in.
//  - mul/div: T3: Gra out, Yin. T4: Grb out, ALUselect, Zin. T5: Zlowout LOin. T6: Zhighout HIin.
//  - ldi: T3: Grb out Yin. T4: Cout ADD Zin. T5: Zlowout Gra in.
//  - ld: T3/T4 as ldi. T5: Zlowout MARin. T6: MDRread MDRin mem_read (hold until mem_ready). T7: MDRout Gra in.
//  - st: T3-T5 as ld. T6: Gra out MDRin (MDRread=0). T7: mem_write (hold until mem_ready).
//  - br: T3: Gra out (CON FF samples). T4: PCout Yin. T5: Cout ADD Zin. T6: Zlowout PCin only if con_ff=1.
//  - jr: T3: Gra out PCin.
//  - mfhi/mflo: T3: HIout or LOout, Gra in.
//  - nop: no T3 work. Return to T0 after T2.
//  - halt: enter HALT; run=0 and all strobes 0. HALT is left only via clear.
//  - Last T-state of every instruction -> T0, or -> HALT if stop=1 in that cycle. stop is ignored mid-instruction.
//  - mem_ready is sampled only in wait states. Requests stay asserted, stable, until the cycle mem_ready=1. Advance on that edge.
//  - With mem_ready tied high: add takes 6 cycles, ld takes 8 cycles.
//  - Rb=R0 in ld/ldi/st addressing is passed as-is (no BAout special case).
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined: an undefined opcode at T2 -> HALT, and sets illegal=1 until clear.
//  CTRL_ILLEGAL_TRAP_EN undefined: an undefined opcode executes as nop; illegal is tied 0.
// STRUCTURE
//  ctrl_pkg: opcode localparams, ALUselect codes (ADD=0000 SUB AND OR SHR SHL ROR ROL MUL DIV NEG NOT), T-state encoding.
//  Sub-module reg_select_decode: ir + Gra/Grb/Grc + Rin/Rout -> one-hot R_in[15:0]/R_out[15:0].
// TESTING
//  1. clear=1 for 2 cycles, then low -> all outputs 0 in RST; T0 strobes (PCout MARin IncPC) on the next cycle.
//  2. ir=0x19890000 (add R3,R1,R2), mem_ready=1 -> R_out=0x0002+Yin; R_out=0x0004+Zin with ALUselect=ADD; R_in=0x0008+Zlowout; 6 cycles total.
//  3. ir=0x01000055 (ld R2,0x55(R0)), mem_ready held low 3 cycles in T6 -> mem_read stays high 4 cycles; then MDRout with R_in=0x0004.
//  4. br with con_ff=0, then with con_ff=1 -> PCin absent in T6 for the first; PCin+Zlowout in T6 for the second.
//  5. stop=1 during T4 of add -> instruction completes, enters HALT, run=0; clear in the middle of a T1 wait -> RST, mem_read drops.
//  6. Opcode 11111 -> HALT with illegal=1 when the macro is defined; nop behaviour and illegal=0 when it is not.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU operation codes,
// T-state encoding and per-opcode sequencing helpers.
package ctrl_pkg;

  localparam int NREGS = 16;
  localparam int OPW   = 5;

  typedef logic [OPW-1:0] opcode_t;

  localparam opcode_t OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3;
  localparam opcode_t OP_SUB  = 5'd4,  OP_SHR  = 5'd5,  OP_SHL  = 5'd6,  OP_ROR  = 5'd7;
  localparam opcode_t OP_ROL  = 5'd8,  OP_AND  = 5'd9,  OP_OR   = 5'd10, OP_ADDI = 5'd11;
  localparam opcode_t OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14, OP_DIV  = 5'd15;
  localparam opcode_t OP_NEG  = 5'd16, OP_NOT  = 5'd17, OP_BR   = 5'd18, OP_JR   = 5'd19;
  localparam opcode_t OP_MFHI = 5'd23, OP_MFLO = 5'd24, OP_NOP  = 5'd25, OP_HALT = 5'd26;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,  ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4, ALU_SHL = 4'd5, ALU_ROR = 4'd6,  ALU_ROL = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8, ALU_DIV = 4'd9, ALU_NEG = 4'd10, ALU_NOT = 4'd11;

  // T0..T7 are consecutive so the sequencer can advance by simple increment.
  typedef enum logic [3:0] {
    ST_T0   = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_RST  = 4'd8,
    ST_HALT = 4'd9
  } tstate_e;

  function automatic logic opDefined(input opcode_t op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_MUL, OP_DIV, OP_NEG, OP_NOT,
      OP_BR, OP_JR, OP_MFHI, OP_MFLO, OP_NOP, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Undefined opcodes, nop and halt all finish at the end of fetch.
  function automatic tstate_e lastStep(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:   return ST_T5;
      OP_NEG, OP_NOT:                     return ST_T4;
      OP_MUL, OP_DIV, OP_BR:              return ST_T6;
      OP_LD, OP_ST:                       return ST_T7;
      OP_JR, OP_MFHI, OP_MFLO:            return ST_T3;
      default:                            return ST_T2;
    endcase
  endfunction

  function automatic logic [3:0] aluCode(input opcode_t op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR,  OP_ORI:  return ALU_OR;
      OP_SHR:          return ALU_SHR;
      OP_SHL:          return ALU_SHL;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decode.sv
// Turns the Gra/Grb/Grc field select plus Rin/Rout enables into one-hot GPR strobes.
module reg_select_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]      ir,
  input  logic             Gra,
  input  logic             Grb,
  input  logic             Grc,
  input  logic             Rin,
  input  logic             Rout,
  output logic [NREGS-1:0] R_in,
  output logic [NREGS-1:0] R_out
);

  logic [3:0]       sel;
  logic [NREGS-1:0] oneHot;
  logic             unusedIrBits;

  assign unusedIrBits = ^{ir[31:27], ir[14:0]};

  always_comb begin
    sel = 4'd0;
    if (Gra)      sel = ir[26:23];
    else if (Grb) sel = ir[22:19];
    else if (Grc) sel = ir[18:15];
  end

  assign oneHot = {{(NREGS-1){1'b0}}, 1'b1} << sel;
  assign R_in   = Rin  ? oneHot : '0;
  assign R_out  = Rout ? oneHot : '0;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit, one T-state per clock with memory-ready stalls.
// Define CTRL_ILLEGAL_TRAP_EN to halt on undefined opcodes and raise the sticky illegal flag.
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  input  logic             mem_ready,
  input  logic             stop,
  output logic [NREGS-1:0] R_in,
  output logic [NREGS-1:0] R_out,
  output logic             PCin,
  output logic             PCout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             MDRread,
  output logic             HIin,
  output logic             HIout,
  output logic             LOin,
  output logic             LOout,
  output logic             IncPC,
  output logic             Zhighout,
  output logic             Zlowout,
  output logic             Cout,
  output logic [3:0]       ALUselect,
  output logic             mem_read,
  output logic             mem_write,
  output logic             run,
  output logic             illegal
);

  tstate_e state_q, state_d;
  opcode_t op;
  logic    isWait, trapHit;
  logic    gra, grb, grc, rinEn, routEn;
  logic    rType, immType, mulDiv, negNot, memAddr;

  assign op      = ir[31:27];
  assign rType   = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL};
  assign immType = op inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign mulDiv  = op inside {OP_MUL, OP_DIV};
  assign negNot  = op inside {OP_NEG, OP_NOT};
  assign memAddr = op inside {OP_LDI, OP_LD, OP_ST};

  assign isWait = (state_q == ST_T1) ||
                  (state_q == ST_T6 && op == OP_LD) ||
                  (state_q == ST_T7 && op == OP_ST);

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  assign trapHit = (state_q == ST_T2) && !opDefined(op);

  always_ff @(posedge clock) begin
    if (clear)        illegal_q <= 1'b0;
    else if (trapHit) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign trapHit = 1'b0;
  assign illegal = 1'b0;
`endif

  // stop only matters on the cycle an instruction retires; waits hold the current state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: begin
        if (isWait && !mem_ready)                                state_d = state_q;
        else if (trapHit || (state_q == ST_T2 && op == OP_HALT)) state_d = ST_HALT;
        else if (state_q == lastStep(op))                        state_d = stop ? ST_HALT : ST_T0;
        else                                                     state_d = tstate_e'(state_q + 4'd1);
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) state_q <= ST_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    {PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, MDRread} = '0;
    {HIin, HIout, LOin, LOout, IncPC, Zhighout, Zlowout, Cout}   = '0;
    {gra, grb, grc, rinEn, routEn}                               = '0;
    ALUselect = ALU_ADD;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    run       = (state_q != ST_RST) && (state_q != ST_HALT);
    case (state_q)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      ST_T1: begin MDRread = 1'b1; MDRin = 1'b1; mem_read = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        if (rType || immType || memAddr) begin grb = 1'b1; routEn = 1'b1; Yin = 1'b1; end
        else if (negNot) begin grb = 1'b1; routEn = 1'b1; ALUselect = aluCode(op); Zin = 1'b1; end
        else if (mulDiv) begin gra = 1'b1; routEn = 1'b1; Yin = 1'b1; end
        else if (op == OP_BR) begin gra = 1'b1; routEn = 1'b1; end
        else if (op == OP_JR) begin gra = 1'b1; routEn = 1'b1; PCin = 1'b1; end
        else if (op == OP_MFHI) begin HIout = 1'b1; gra = 1'b1; rinEn = 1'b1; end
        else if (op == OP_MFLO) begin LOout = 1'b1; gra = 1'b1; rinEn = 1'b1; end
      end
      ST_T4: begin
        if (rType) begin grc = 1'b1; routEn = 1'b1; ALUselect = aluCode(op); Zin = 1'b1; end
        else if (immType) begin Cout = 1'b1; ALUselect = aluCode(op); Zin = 1'b1; end
        else if (memAddr) begin Cout = 1'b1; ALUselect = ALU_ADD; Zin = 1'b1; end
        else if (negNot) begin Zlowout = 1'b1; gra = 1'b1; rinEn = 1'b1; end
        else if (mulDiv) begin grb = 1'b1; routEn = 1'b1; ALUselect = aluCode(op); Zin = 1'b1; end
        else if (op == OP_BR) begin PCout = 1'b1; Yin = 1'b1; end
      end
      ST_T5: begin
        if (rType || immType || op == OP_LDI) begin Zlowout = 1'b1; gra = 1'b1; rinEn = 1'b1; end
        else if (op == OP_LD || op == OP_ST) begin Zlowout = 1'b1; MARin = 1'b1; end
        else if (mulDiv) begin Zlowout = 1'b1; LOin = 1'b1; end
        else if (op == OP_BR) begin Cout = 1'b1; ALUselect = ALU_ADD; Zin = 1'b1; end
      end
      ST_T6: begin
        if (mulDiv) begin Zhighout = 1'b1; HIin = 1'b1; end
        else if (op == OP_LD) begin MDRread = 1'b1; MDRin = 1'b1; mem_read = 1'b1; end
        else if (op == OP_ST) begin gra = 1'b1; routEn = 1'b1; MDRin = 1'b1; end
        else if (op == OP_BR && con_ff) begin Zlowout = 1'b1; PCin = 1'b1; end
      end
      ST_T7: begin
        if (op == OP_LD) begin MDRout = 1'b1; gra = 1'b1; rinEn = 1'b1; end
        else if (op == OP_ST) mem_write = 1'b1;
      end
      default: ;
    endcase
  end

  reg_select_decode uRegSelect (
    .ir   (ir),
    .Gra  (gra),
    .Grb  (grb),
    .Grc  (grc),
    .Rin  (rinEn),
    .Rout (routEn),
    .R_in (R_in),
    .R_out(R_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus random instructions, each checked
// cycle by cycle against a micro-step list built from the instruction-level rules.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear, con_ff, mem_ready, stop;
  logic [31:0] ir;
  logic [15:0] R_in, R_out;
  logic        PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, MDRread;
  logic        HIin, HIout, LOin, LOout, IncPC, Zhighout, Zlowout, Cout;
  logic [3:0]  ALUselect;
  logic        mem_read, mem_write, run, illegal;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready), .stop(stop),
    .R_in(R_in), .R_out(R_out), .PCin(PCin), .PCout(PCout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .MDRread(MDRread), .HIin(HIin), .HIout(HIout),
    .LOin(LOin), .LOout(LOout), .IncPC(IncPC), .Zhighout(Zhighout), .Zlowout(Zlowout), .Cout(Cout),
    .ALUselect(ALUselect), .mem_read(mem_read), .mem_write(mem_write), .run(run), .illegal(illegal)
  );

  always #5 clock = ~clock;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [16:0] M_PCIN = 17'h00001, M_PCOUT = 17'h00002, M_IRIN = 17'h00004;
  localparam logic [16:0] M_YIN = 17'h00008, M_ZIN = 17'h00010, M_MARIN = 17'h00020;
  localparam logic [16:0] M_MDRIN = 17'h00040, M_MDROUT = 17'h00080, M_MDRREAD = 17'h00100;
  localparam logic [16:0] M_HIIN = 17'h00200, M_HIOUT = 17'h00400, M_LOIN = 17'h00800;
  localparam logic [16:0] M_LOOUT = 17'h01000, M_INCPC = 17'h02000, M_ZHIGH = 17'h04000;
  localparam logic [16:0] M_ZLOW = 17'h08000, M_COUT = 17'h10000;

  localparam logic [4:0] C_LD = 5'd0, C_LDI = 5'd1, C_ST = 5'd2, C_ADD = 5'd3, C_SUB = 5'd4;
  localparam logic [4:0] C_SHR = 5'd5, C_SHL = 5'd6, C_ROR = 5'd7, C_ROL = 5'd8, C_AND = 5'd9;
  localparam logic [4:0] C_OR = 5'd10, C_ADDI = 5'd11, C_ANDI = 5'd12, C_ORI = 5'd13, C_MUL = 5'd14;
  localparam logic [4:0] C_DIV = 5'd15, C_NEG = 5'd16, C_NOT = 5'd17, C_BR = 5'd18, C_JR = 5'd19;
  localparam logic [4:0] C_MFHI = 5'd23, C_MFLO = 5'd24, C_NOP = 5'd25, C_HALT = 5'd26;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic [16:0] strobes;
    logic [3:0]  alu;
    logic        mr;
    logic        mw;
    logic        run;
    logic        ill;
  } outv_t;

  typedef struct {
    outv_t o;
    bit    isWait;
  } step_t;

  int     checks = 0;
  int     errors = 0;
  bit     expIllegal = 1'b0;
  step_t  steps[$];
  logic [4:0] defOps[$];
  logic [4:0] undefOps[8] = '{5'd20, 5'd21, 5'd22, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31};

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [56:0] actual, input logic [56:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic outv_t sampleDut();
    outv_t o;
    o.rin     = R_in;
    o.rout    = R_out;
    o.strobes = {Cout, Zlowout, Zhighout, IncPC, LOout, LOin, HIout, HIin, MDRread,
                 MDRout, MDRin, MARin, Zin, Yin, IRin, PCout, PCin};
    o.alu     = ALUselect;
    o.mr      = mem_read;
    o.mw      = mem_write;
    o.run     = run;
    o.ill     = illegal;
    return o;
  endfunction

  function automatic outv_t mk(logic [16:0] m, logic [15:0] rin, logic [15:0] rout,
                               logic [3:0] alu, logic mr, logic mw);
    outv_t o;
    o.rin = rin; o.rout = rout; o.strobes = m; o.alu = alu;
    o.mr = mr; o.mw = mw; o.run = 1'b1; o.ill = 1'b0;
    return o;
  endfunction

  function automatic outv_t idleOut(logic ill);
    outv_t o;
    o = '0;
    o.ill = ill;
    return o;
  endfunction

  function automatic logic [15:0] oh(logic [3:0] r);
    return 16'h0001 << r;
  endfunction

  function automatic bit isDefined(logic [4:0] op);
    return (op <= C_JR) || (op >= C_MFHI && op <= C_HALT);
  endfunction

  function automatic logic [3:0] aluFor(logic [4:0] op);
    case (op)
      C_SUB: return 4'd1;
      C_AND, C_ANDI: return 4'd2;
      C_OR, C_ORI: return 4'd3;
      C_SHR: return 4'd4;
      C_SHL: return 4'd5;
      C_ROR: return 4'd6;
      C_ROL: return 4'd7;
      C_MUL: return 4'd8;
      C_DIV: return 4'd9;
      C_NEG: return 4'd10;
      C_NOT: return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  task automatic push(input outv_t o, input bit w);
    step_t s;
    s.o = o;
    s.isWait = w;
    steps.push_back(s);
  endtask

  // Expected micro-step list for one instruction, fetch included.
  task automatic buildSteps(input logic [31:0] instr, input logic cf);
    logic [4:0] op;
    logic [3:0] ra, rb, rc, a;
    op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
    a = aluFor(op);
    steps.delete();
    push(mk(M_PCOUT | M_MARIN | M_INCPC, 0, 0, 0, 0, 0), 0);
    push(mk(M_MDRREAD | M_MDRIN, 0, 0, 0, 1, 0), 1);
    push(mk(M_MDROUT | M_IRIN, 0, 0, 0, 0, 0), 0);
    case (op)
      C_ADD, C_SUB, C_AND, C_OR, C_SHR, C_SHL, C_ROR, C_ROL: begin
        push(mk(M_YIN, 0, oh(rb), 0, 0, 0), 0);
        push(mk(M_ZIN, 0, oh(rc), a, 0, 0), 0);
        push(mk(M_ZLOW, oh(ra), 0, 0, 0, 0), 0);
      end
      C_ADDI, C_ANDI, C_ORI, C_LDI: begin
        push(mk(M_YIN, 0, oh(rb), 0, 0, 0), 0);
        push(mk(M_COUT | M_ZIN, 0, 0, a, 0, 0), 0);
        push(mk(M_ZLOW, oh(ra), 0, 0, 0, 0), 0);
      end
      C_NEG, C_NOT: begin
        push(mk(M_ZIN, 0, oh(rb), a, 0, 0), 0);
        push(mk(M_ZLOW, oh(ra), 0, 0, 0, 0), 0);
      end
      C_MUL, C_DIV: begin
        push(mk(M_YIN, 0, oh(ra), 0, 0, 0), 0);
        push(mk(M_ZIN, 0, oh(rb), a, 0, 0), 0);
        push(mk(M_ZLOW | M_LOIN, 0, 0, 0, 0, 0), 0);
        push(mk(M_ZHIGH | M_HIIN, 0, 0, 0, 0, 0), 0);
      end
      C_LD, C_ST: begin
        push(mk(M_YIN, 0, oh(rb), 0, 0, 0), 0);
        push(mk(M_COUT | M_ZIN, 0, 0, 0, 0, 0), 0);
        push(mk(M_ZLOW | M_MARIN, 0, 0, 0, 0, 0), 0);
        if (op == C_LD) begin
          push(mk(M_MDRREAD | M_MDRIN, 0, 0, 0, 1, 0), 1);
          push(mk(M_MDROUT, oh(ra), 0, 0, 0, 0), 0);
        end else begin
          push(mk(M_MDRIN, 0, oh(ra), 0, 0, 0), 0);
          push(mk(0, 0, 0, 0, 0, 1), 1);
        end
      end
      C_BR: begin
        push(mk(0, 0, oh(ra), 0, 0, 0), 0);
        push(mk(M_PCOUT | M_YIN, 0, 0, 0, 0, 0), 0);
        push(mk(M_COUT | M_ZIN, 0, 0, 0, 0, 0), 0);
        push(mk(cf ? (M_ZLOW | M_PCIN) : 17'h0, 0, 0, 0, 0, 0), 0);
      end
      C_JR:   push(mk(M_PCIN, 0, oh(ra), 0, 0, 0), 0);
      C_MFHI: push(mk(M_HIOUT, oh(ra), 0, 0, 0, 0), 0);
      C_MFLO: push(mk(M_LOOUT, oh(ra), 0, 0, 0, 0), 0);
      default: ;
    endcase
  endtask

  // Runs one instruction; memWait<0 picks random stall lengths, stop held from step stopFrom on.
  task automatic applyStimulus(input logic [31:0] instr, input logic cf, input int memWait,
                               input int stopFrom, output bit halted);
    int  nWait;
    bit  isLast;
    logic [4:0] op;
    op = instr[31:27];
    buildSteps(instr, cf);
    foreach (steps[i]) begin
      nWait  = steps[i].isWait ? ((memWait >= 0) ? memWait : $urandom_range(0, 2)) : 0;
      isLast = (i == steps.size() - 1);
      for (int k = 0; k <= nWait; k++) begin
        @(negedge clock);
        ir     = instr;
        con_ff = cf;
        mem_ready = steps[i].isWait ? (k == nWait) : 1'($urandom_range(0, 1));
        if (i >= stopFrom) stop = 1'b1;
        else if (isLast)   stop = 1'b0;
        else               stop = 1'($urandom_range(0, 1));
        #1 checkOutput($sformatf("op%0d_step%0d_cyc%0d", op, i, k), sampleDut(), steps[i].o);
      end
    end
    halted = (stopFrom < steps.size()) || (op == C_HALT) || (TRAP && !isDefined(op));
    if (TRAP && !isDefined(op)) expIllegal = 1'b1;
  endtask

  task automatic doReset();
    @(negedge clock);
    clear = 1'b1; stop = 1'b0; mem_ready = 1'b0;
    @(negedge clock);
    #1 checkOutput("rst_hold1", sampleDut(), idleOut(1'b0));
    @(negedge clock);
    #1 checkOutput("rst_hold2", sampleDut(), idleOut(1'b0));
    clear = 1'b0;
    #1 checkOutput("rst_release", sampleDut(), idleOut(1'b0));
    expIllegal = 1'b0;
  endtask

  task automatic recoverFromHalt();
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      mem_ready = 1'($urandom_range(0, 1));
      stop      = 1'($urandom_range(0, 1));
      #1 checkOutput($sformatf("halt_cyc%0d", k), sampleDut(), idleOut(expIllegal));
    end
    doReset();
  endtask

  task automatic clearDuringFetch();
    @(negedge clock);
    mem_ready = 1'b1; stop = 1'b0;
    #1 checkOutput("cdf_t0", sampleDut(), mk(M_PCOUT | M_MARIN | M_INCPC, 0, 0, 0, 0, 0));
    @(negedge clock);
    mem_ready = 1'b0;
    #1 checkOutput("cdf_t1_wait", sampleDut(), mk(M_MDRREAD | M_MDRIN, 0, 0, 0, 1, 0));
    @(negedge clock);
    clear = 1'b1;
    #1 checkOutput("cdf_t1_clear", sampleDut(), mk(M_MDRREAD | M_MDRIN, 0, 0, 0, 1, 0));
    @(negedge clock);
    mem_ready = 1'b1;
    #1 checkOutput("cdf_rst", sampleDut(), idleOut(1'b0));
    clear = 1'b0;
    #1 checkOutput("cdf_release", sampleDut(), idleOut(1'b0));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          halted;
    logic [4:0]  op;
    logic [31:0] instr;
    int          r, stopFrom;
    clear = 1'b1; con_ff = 1'b0; mem_ready = 1'b0; stop = 1'b0; ir = 32'h0;
    for (int o = 0; o <= 25; o++) if (isDefined(5'(o))) defOps.push_back(5'(o));

    doReset();
    applyStimulus(32'h19890000, 1'b0, 0, 99, halted);       // add R3,R1,R2
    applyStimulus(32'h01000055, 1'b0, 3, 99, halted);       // ld R2,0x55(R0)
    applyStimulus(32'h92000020, 1'b0, 0, 99, halted);       // br R4 not taken
    applyStimulus(32'h92000020, 1'b1, 1, 99, halted);       // br R4 taken
    applyStimulus(32'h12B00010, 1'b0, 2, 99, halted);       // st R5,0x10(R6)
    applyStimulus(32'h73C00000, 1'b0, 0, 99, halted);       // mul R7,R8
    applyStimulus(32'hC8000000, 1'b0, 0, 99, halted);       // nop
    applyStimulus(32'h19890000, 1'b0, 0, 4, halted);        // add with stop from T4
    if (halted) recoverFromHalt();
    clearDuringFetch();
    applyStimulus(32'hF8000000, 1'b0, 0, 99, halted);       // undefined opcode 31
    if (halted) recoverFromHalt();
    applyStimulus(32'hD0000000, 1'b0, 0, 99, halted);       // halt
    if (halted) recoverFromHalt();

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0)      op = undefOps[$urandom_range(0, 7)];
      else if (r == 1) op = C_HALT;
      else             op = defOps[$urandom_range(0, defOps.size() - 1)];
      instr    = {op, 27'($urandom)};
      stopFrom = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 99;
      applyStimulus(instr, 1'($urandom_range(0, 1)), -1, stopFrom, halted);
      if (halted) recoverFromHalt();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
